// File: rtl/clint_axil_bridge.sv
// AXI4-Lite slave front end for the CLINT mtime counter.
// Reads are tear-free across the lo/hi word pair; writes are always refused.
module clint_axil_bridge #(
  parameter logic [31:0] BASE = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [31:0] clint_addr_o,
  input  logic [31:0] clint_data_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_LO = 2'd1;
  localparam logic [1:0] S_RD_HI = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] HI_ADDR = BASE + 32'd4;

  logic [1:0]  state;
  logic [31:0] lo_q;
  logic [31:0] hi_snap;
  logic        snap_valid;
  logic        rd_lo_path;
  logic        resp_snap;

  logic        aw_got, w_got, aw_hit;
  logic        aw_hs, w_hs, hit_now;

  // Write payload carries no meaning for a read-only register.
  logic unused_wpayload;
  assign unused_wpayload = ^{wdata, wstrb};

  // ---------------------------------------------------------------- read path
  assign arready = (state == S_IDLE) && !reset;
  assign rvalid  = (state == S_RESP);

  always_comb begin
    clint_addr_o = 32'd0;
    case (state)
      S_RD_LO: clint_addr_o = BASE;
      S_RD_HI: clint_addr_o = HI_ADDR;
      default: clint_addr_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rdata      <= 32'd0;
      rresp      <= RESP_OKAY;
      lo_q       <= 32'd0;
      hi_snap    <= 32'd0;
      snap_valid <= 1'b0;
      rd_lo_path <= 1'b0;
      resp_snap  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arvalid) begin
            if (araddr == BASE) begin
              rd_lo_path <= 1'b1;
              state      <= S_RD_LO;
            end else if (araddr == HI_ADDR) begin
              if (snap_valid) begin
                rdata     <= hi_snap;
                rresp     <= RESP_OKAY;
                resp_snap <= 1'b1;
                state     <= S_RESP;
              end else begin
                rd_lo_path <= 1'b0;
                state      <= S_RD_HI;
              end
            end else begin
              rdata     <= 32'd0;
              rresp     <= RESP_DECERR;
              resp_snap <= 1'b0;
              state     <= S_RESP;
            end
          end
        end
        S_RD_LO: begin
          lo_q  <= clint_data_i;
          state <= S_RD_HI;
        end
        S_RD_HI: begin
          rresp     <= RESP_OKAY;
          resp_snap <= 1'b0;
          state     <= S_RESP;
          if (rd_lo_path) begin
            rdata      <= lo_q;
            // The counter ticked once between samples; a lo of all-ones means
            // the hi word we just saw already includes the carry.
            hi_snap    <= (lo_q == 32'hFFFF_FFFF) ? clint_data_i - 32'd1 : clint_data_i;
            snap_valid <= 1'b1;
          end else begin
            rdata <= clint_data_i;
          end
        end
        default: begin
          if (rready) begin
            state <= S_IDLE;
            if (resp_snap) snap_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------- write path
  assign awready = !aw_got && !bvalid && !reset;
  assign wready  = !w_got  && !bvalid && !reset;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign hit_now = (awaddr == BASE) || (awaddr == HI_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_hit <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end else if (bvalid) begin
      if (bready) bvalid <= 1'b0;
    end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
      bvalid <= 1'b1;
      bresp  <= (aw_got ? aw_hit : hit_now) ? RESP_SLVERR : RESP_DECERR;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_hit <= hit_now;
      end
      if (w_hs) w_got <= 1'b1;
    end
  end

endmodule

// File: doc/clint_axil_bridge.md
# clint_axil_bridge

AXI4-Lite slave front end for the CLINT `mtime` counter; it sits between the system crossbar and the CLINT core. It translates crossbar read bursts into the CLINT's combinational address/data port. It guarantees a tear-free 64-bit `mtime` read: a low-word read followed by a high-word read returns the same snapshot. `mtime` is read-only, so every write is answered with an error response.

## Interface
Parameters:
- `BASE`, 32'h0200_0000: address of the `mtime` low word; the high word is at `BASE+4`.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `araddr`  in  32: read address.
- `arvalid`  in  1: read address valid.
- `arready`  out  1: read address ready.
- `rdata`  out  32: read data.
- `rresp`  out  2: read response (OKAY 2'b00, DECERR 2'b11).
- `rvalid`  out  1: read data valid.
- `rready`  in  1: read data ready.
- `awaddr`  in  32: write address.
- `awvalid`  in  1: write address valid.
- `awready`  out  1: write address ready.
- `wdata`  in  32: write data, ignored.
- `wstrb`  in  4: write strobes, ignored.
- `wvalid`  in  1: write data valid.
- `wready`  out  1: write data ready.
- `bresp`  out  2: write response (SLVERR 2'b10, DECERR 2'b11).
- `bvalid`  out  1: write response valid.
- `bready`  in  1: write response ready.
- `clint_addr_o`  out  32: address driven to the CLINT core.
- `clint_data_i`  in  32: combinational data returned by the CLINT core.

## Operation
- Read FSM states: IDLE, RD_LO, RD_HI, RESP.
- `arready` = 1 only in IDLE. A handshake latches `araddr` and leaves IDLE.
- Read of `BASE`:
  - IDLE → RD_LO: drive `clint_addr_o=BASE` and capture `lo`.
  - RD_LO → RD_HI: drive `BASE+4` and capture `hi`.
  - The CLINT advanced exactly one tick between the two samples. If the captured `lo`==32'hFFFF_FFFF, store `hi_snap = hi-1` (32-bit wrap); otherwise store `hi_snap = hi`.
  - Set `snap_valid`=1, then go to RESP with `rdata=lo` and OKAY.
- Read of `BASE+4`:
  - If `snap_valid`: go IDLE → RESP directly, return `hi_snap` with OKAY, then clear `snap_valid` on the R handshake.
  - Otherwise: IDLE → RD_HI, drive `BASE+4`, return live `hi` with OKAY; `hi_snap` and `snap_valid` are not updated.
- Any other read address: go IDLE → RESP with `rdata`=0 and DECERR. `snap_valid` is unchanged.
- RESP holds `rvalid`=1 and stable `rdata`/`rresp` until `rready`, then returns to IDLE.
- `clint_addr_o`=0 in IDLE and RESP.
- Write path (independent of the read FSM):
  - `awready`/`wready` are 1 while the corresponding beat has not been captured and `bvalid`=0. AW and W may arrive in either order or in the same cycle.
  - Once both beats are captured, assert `bvalid` the next cycle. `bresp` is SLVERR if `awaddr` ∈ {`BASE`, `BASE+4`}, otherwise DECERR.
  - Hold `bvalid` until `bready`. The CLINT is never driven by writes.

## Timing
- Reset values: `arready`=0 during reset, then 1 in the first IDLE cycle. `rvalid`=0, `rdata`=0, `rresp`=0, `bvalid`=0, `bresp`=0, `awready`=0 during reset, `wready`=0 during reset, `clint_addr_o`=0, `snap_valid`=0, FSM=IDLE.
- Read latency, counted from the AR handshake at cycle 0 to first `rvalid`:
  - low word: cycle 3.
  - high word, live: cycle 2.
  - high word from snapshot: cycle 1.
  - decode error: cycle 1.
- Write latency: `bvalid` one cycle after the later of the AW and W handshakes.
- Back-to-back reads: a new AR is accepted the cycle after the R handshake (IDLE re-entry). There is no R-to-AR combinational path.
- Reset asserted mid-transaction returns everything to reset values the next cycle. Any pending response is dropped and the snapshot is invalidated.
- Simultaneous read and write traffic proceeds fully in parallel.

## Test plan
- CLINT `mtime` preloaded to 0x0000_0001_FFFF_FFFE and free-running. Read `BASE` at cycle 0 → `rdata`=0xFFFF_FFFF (captured in RD_LO, cycle 1) at cycle 3. Then read `BASE+4` → `rdata`=0x0000_0001 from the snapshot, one-cycle latency, even though the live high word is 2.
- Read `BASE+4` with no prior low read and `mtime`=0x0000_0005_0000_0010 → live 0x0000_0005, `rvalid` at cycle 2, `snap_valid` stays 0.
- Read 0x0200_0008 → `rdata`=0, `rresp`=2'b11 at cycle 1. A following `BASE+4` read still uses a snapshot taken earlier.
- `rready` held low for 5 cycles in RESP → `rvalid`, `rdata` and `rresp` stable throughout, `arready`=0, and no second AR is accepted.
- W presented 3 cycles before AW at `BASE` → `bresp`=2'b10, `bvalid` the cycle after the AW handshake. AW at 0x3000_0000 → `bresp`=2'b11. `mtime` is unaffected in both cases.
- Assert `reset` during RD_HI → the next cycle has all outputs at reset values. A subsequent `BASE+4` read returns the live value, not a snapshot.
